// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the word-wide memory port of mem_access_unit.
// The slave side is the access unit; the master side is the datapath and memory.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/mem_access_unit.sv
// Big-endian byte/halfword/word load-store front end for a word memory with
// combinational read and synchronous write; sub-word stores use read-modify-write.
module mem_access_unit #(
   parameter int MEM_WORDS = 64
) (
   input logic             clk,
   input logic             reset,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   localparam logic [1:0]  SZ_BYTE    = 2'b00;
   localparam logic [1:0]  SZ_HALF    = 2'b01;
   localparam logic [1:0]  SZ_WORD    = 2'b10;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

   state_t      state, state_nxt;
   logic        wr_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merged_q;
   logic        err_q;
   logic [31:0] rdata_q;

   function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr[0];
         SZ_WORD: bad = (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad || (addr >= ADDR_LIMIT);
   endfunction

   // Lane 0 is the most significant byte of the word (big-endian).
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] ofs);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = word[8*(3-ofs) +: 8];
      h = ofs[1] ? word[15:0] : word[31:16];
      case (size)
         SZ_BYTE: r = uns ? {24'd0, b} : 32'(b);
         SZ_HALF: r = uns ? {16'd0, h} : 32'(h);
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] ofs);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: r[8*(3-ofs) +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (ofs[1]) r[15:0]  = wdata[15:0];
            else        r[31:16] = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_a      = {addr_q[31:2], 2'b00};
      bus.mem_wd     = wdata_q;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               state_nxt = req_error(bus.req_size, bus.req_addr) ? RESP : ACCESS;
         end
         ACCESS: begin
            if (wr_q && size_q == SZ_WORD) begin
               bus.mem_we = 1'b1;
               state_nxt  = RESP;
            end else if (wr_q) begin
               state_nxt  = WRITE;
            end else begin
               state_nxt  = RESP;
            end
         end
         WRITE: begin
            bus.mem_wd = merged_q;
            bus.mem_we = 1'b1;
            state_nxt  = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A reset landing mid-store must not commit the write.
      if (reset) bus.mem_we = 1'b0;
   end

   assign bus.resp_err   = err_q;
   assign bus.resp_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q     <= 1'b0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         merged_q <= 32'd0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  wr_q    <= bus.req_write;
                  size_q  <= bus.req_size;
                  uns_q   <= bus.req_unsigned;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  err_q   <= req_error(bus.req_size, bus.req_addr);
                  rdata_q <= 32'd0;
               end
            end
            ACCESS: begin
               if (!wr_q) rdata_q  <= load_extend(bus.mem_rd, size_q, uns_q, addr_q[1:0]);
               else       merged_q <= store_merge(bus.mem_rd, wdata_q, size_q, addr_q[1:0]);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sub-word load/store front end placed directly upstream of the multicycle instruction/data memory. It accepts one datapath request at a time through a valid/ready handshake and drives the memory's clk/we/a/wd/rd interface. That memory has a combinational read and a synchronous write. The block performs byte, halfword and word accesses in big-endian order. Sub-word stores use read-modify-write. Loads return sign- or zero-extended data. Misaligned and out-of-range requests are rejected without touching memory.

Parameters:
MEM_WORDS, 64, number of 32-bit words in the attached memory; valid byte addresses are 0 to 4*MEM_WORDS-1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block idle and able to accept a request
req_write  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=halfword, 10=word; 11 is illegal and treated as an error
req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  qualified by resp_valid: misaligned, out-of-range or illegal size
resp_rdata  output  32  qualified by resp_valid: extended load data; 0 for stores and errors
mem_we  output  1  to memory we
mem_a  output  32  to memory a; always word-aligned ([1:0]=00)
mem_wd  output  32  to memory wd
mem_rd  input  32  from memory rd (combinational on mem_a)

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP. A single request is in flight; there is no queueing.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_a=0, mem_wd=0, all internal request registers cleared.
- mem_we is forced to 0 in any cycle where reset=1, so a reset that lands mid-store writes nothing.
- IDLE:
  - req_ready=1; mem_we=0.
  - Acceptance occurs at a rising edge where req_valid & req_ready. On acceptance, latch write, size, unsigned, addr and wdata.
  - Error check at acceptance: size=11, half with addr[0]=1, word with addr[1:0]!=00, or addr >= 4*MEM_WORDS. Any error goes to RESP with err=1. Otherwise go to ACCESS.
- In ACCESS, WRITE and RESP, req_ready=0, and req_valid is ignored.
- ACCESS: mem_a = {addr[31:2],2'b00}.
  - Load: select a lane from mem_rd and extend it; register the result into resp_rdata; go to RESP.
  - Byte lanes: offset 0=[31:24], 1=[23:16], 2=[15:8], 3=[7:0].
  - Halfword lanes: offset 0=[31:16], 2=[15:0].
  - Word store: mem_we=1, mem_wd=wdata; go to RESP.
  - Sub-word store: register a merge of mem_rd with the wdata lane (other bytes unchanged); go to WRITE.
- WRITE: mem_a unchanged, mem_wd=merged word, mem_we=1; go to RESP.
- RESP: resp_valid=1 for exactly one cycle with err/rdata; go to IDLE. There is no response backpressure.
- Latency, with acceptance edge = E0:
  - Loads and word stores: resp_valid high in the cycle after E0+1 edges, i.e. the 2nd cycle after acceptance.
  - Sub-word stores: 3rd cycle after acceptance.
  - Errors: 1st cycle after acceptance.
- The earliest next acceptance is at the edge ending the RESP cycle's successor IDLE cycle; req_ready is low during RESP.
- mem_we is high in exactly one cycle per successful store and never for loads or errors.
- Reset asserted in any state returns to IDLE at that edge with no write and no resp_valid; req_ready=1 in the following cycle.

Test Plan:
- Preload word 0x10 with 0x11223344; LW 0x10 -> resp_valid 2 cycles after acceptance, rdata=0x11223344, err=0, mem_we never high.
- Word 0x14 = 0x8899AABB:
  - LB 0x14 -> 0xFFFFFF88; LBU 0x14 -> 0x00000088.
  - LH 0x16 -> 0xFFFFAABB; LHU 0x16 -> 0x0000AABB.
  - LB 0x17 -> 0xFFFFFFBB.
- SB 0x15 with wdata 0x123456CC on 0x8899AABB -> exactly one mem_we pulse with mem_a=0x14 and mem_wd=0x88CCAABB; resp_valid 3 cycles after acceptance; subsequent LW 0x14 reads 0x88CCAABB.
- LW 0x12, LH 0x13, LW 0x100 (MEM_WORDS=64) and size=11 -> each gives resp_valid the cycle after acceptance with err=1, rdata=0, and no mem_we.
- SH 0x14 with wdata 0xBEEF, reset asserted during the WRITE cycle -> no memory write (word stays 0x8899AABB), no resp_valid, req_ready=1 the next cycle.
- req_valid held high for two back-to-back LWs -> second accepted only after the first response; req_ready=0 throughout ACCESS and RESP.
